// File: rtl/dual_issue_ctrl_pkg.sv
// Shared constants for the dual-issue pairing controller: state encoding,
// register-index width and the hard-wired zero register.
package dual_issue_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // Controller states
    localparam logic [0:0] ST_PAIR  = 1'b0;  // first or only cycle of a pair
    localparam logic [0:0] ST_SPLIT = 1'b1;  // slot 1 issued, slot 2 pending

    localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/dual_issue_ctrl_hazard_match.sv
// Load-use match of a single source register against the two EX-stage load
// destinations. Register 0 and unused sources never match.
module dual_issue_ctrl_hazard_match
    import dual_issue_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = dual_issue_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic             ex_load1,
    input  logic [REG_W-1:0] ex_dst1,
    input  logic             ex_load2,
    input  logic [REG_W-1:0] ex_dst2,
    output logic             hit
);

    logic live;

    // A source is live only when it is actually read and is not r0
    always_comb begin
        live = use_src && (src != REG_W'(ZERO_REG));
        hit  = live && ((ex_load1 && (src == ex_dst1)) || (ex_load2 && (src == ex_dst2)));
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue-pairing and hazard controller beside the IF->ID1 register. Decides each
// cycle between dual issue, split issue over two cycles, load-use stall or
// redirect squash, and keeps saturating counts of split and load-use cycles.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = dual_issue_ctrl_pkg::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pair_valid,
    input  logic [REG_W-1:0] s1_dst,
    input  logic [REG_W-1:0] s2_dst,
    input  logic             s1_wr,
    input  logic             s2_wr,
    input  logic [REG_W-1:0] s1_rs,
    input  logic [REG_W-1:0] s1_rt,
    input  logic [REG_W-1:0] s2_rs,
    input  logic [REG_W-1:0] s2_rt,
    input  logic             s1_use_rs,
    input  logic             s1_use_rt,
    input  logic             s2_use_rs,
    input  logic             s2_use_rt,
    input  logic             s1_mem,
    input  logic             s2_mem,
    input  logic             s1_ctrl,
    input  logic             s2_ctrl,
    input  logic             ex_load1,
    input  logic             ex_load2,
    input  logic [REG_W-1:0] ex_dst1,
    input  logic [REG_W-1:0] ex_dst2,
    input  logic             redirect_J,
    input  logic             redirect_JR,
    input  logic             redirect_B,
    output logic             stall_outer,
    output logic             stall_pc,
    output logic             flush_ifid,
    output logic             issue1,
    output logic             issue2,
    output logic [CNT_W-1:0] split_cnt,
    output logic [CNT_W-1:0] luse_cnt
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;
    logic [CNT_W-1:0] luse_cnt_q, luse_cnt_d;
    logic             split_inc, luse_inc;
    logic [3:0]       src_hit;
    logic             luse_s1, luse_s2;
    logic             raw, waw, intra, redirect;

    logic [REG_W-1:0] src_vec [4];
    logic             use_vec [4];

    // Order: s1_rs, s1_rt, s2_rs, s2_rt
    always_comb begin
        src_vec[0] = s1_rs;
        src_vec[1] = s1_rt;
        src_vec[2] = s2_rs;
        src_vec[3] = s2_rt;
        use_vec[0] = s1_use_rs;
        use_vec[1] = s1_use_rt;
        use_vec[2] = s2_use_rs;
        use_vec[3] = s2_use_rt;
    end

    for (genvar i = 0; i < 4; i++) begin : g_match
        dual_issue_ctrl_hazard_match #(
            .REG_W (REG_W)
        ) u_hazard_match (
            .src      (src_vec[i]),
            .use_src  (use_vec[i]),
            .ex_load1 (ex_load1),
            .ex_dst1  (ex_dst1),
            .ex_load2 (ex_load2),
            .ex_dst2  (ex_dst2),
            .hit      (src_hit[i])
        );
    end

    // Hazard classification: load-use per slot and intra-pair conflicts
    always_comb begin
        luse_s1  = src_hit[0] | src_hit[1];
        luse_s2  = src_hit[2] | src_hit[3];
        raw      = s1_wr && (s1_dst != REG_W'(ZERO_REG)) &&
                   ((s2_use_rs && (s2_rs == s1_dst)) || (s2_use_rt && (s2_rt == s1_dst)));
        waw      = s1_wr && s2_wr && (s1_dst != REG_W'(ZERO_REG)) && (s1_dst == s2_dst);
        intra    = raw || waw || (s1_mem && s2_mem) || (s1_ctrl && s2_ctrl);
        redirect = redirect_J || redirect_JR || redirect_B;
    end

    // Issue decision and next state; priority reset > redirect > load-use > split
    always_comb begin
        stall_outer = 1'b0;
        stall_pc    = 1'b0;
        flush_ifid  = 1'b0;
        issue1      = 1'b0;
        issue2      = 1'b0;
        split_inc   = 1'b0;
        luse_inc    = 1'b0;
        state_d     = state_q;
        if (reset) begin
            state_d = ST_PAIR;
        end else if (redirect) begin
            // Squash the pair; any pending slot 2 is dropped
            flush_ifid = 1'b1;
            state_d    = ST_PAIR;
        end else if (state_q == ST_PAIR) begin
            if (pair_valid) begin
                if (luse_s1 || luse_s2) begin
                    stall_outer = 1'b1;
                    stall_pc    = 1'b1;
                    luse_inc    = 1'b1;
                end else if (intra) begin
                    issue1      = 1'b1;
                    stall_outer = 1'b1;
                    stall_pc    = 1'b1;
                    split_inc   = 1'b1;
                    state_d     = ST_SPLIT;
                end else begin
                    issue1 = 1'b1;
                    issue2 = 1'b1;
                end
            end
        end else begin
            // Slot 1 already left; only slot 2 sources matter here
            if (luse_s2) begin
                stall_outer = 1'b1;
                stall_pc    = 1'b1;
                luse_inc    = 1'b1;
            end else begin
                issue2  = 1'b1;
                state_d = ST_PAIR;
            end
        end
    end

    // Saturating counter next values
    always_comb begin
        split_cnt_d = split_cnt_q;
        luse_cnt_d  = luse_cnt_q;
        if (split_inc && (split_cnt_q != '1)) begin
            split_cnt_d = split_cnt_q + CNT_W'(1);
        end
        if (luse_inc && (luse_cnt_q != '1)) begin
            luse_cnt_d = luse_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PAIR;
            split_cnt_q <= '0;
            luse_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            split_cnt_q <= split_cnt_d;
            luse_cnt_q  <= luse_cnt_d;
        end
    end

    assign split_cnt = split_cnt_q;
    assign luse_cnt  = luse_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Self-checking bench for dual_issue_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural pairing model.
module tb_dual_issue_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 5;  // narrow so saturation is reachable
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pair_valid;
    logic [REG_W-1:0] s1_dst, s2_dst;
    logic             s1_wr, s2_wr;
    logic [REG_W-1:0] s1_rs, s1_rt, s2_rs, s2_rt;
    logic             s1_use_rs, s1_use_rt, s2_use_rs, s2_use_rt;
    logic             s1_mem, s2_mem, s1_ctrl, s2_ctrl;
    logic             ex_load1, ex_load2;
    logic [REG_W-1:0] ex_dst1, ex_dst2;
    logic             redirect_J, redirect_JR, redirect_B;
    logic             stall_outer, stall_pc, flush_ifid, issue1, issue2;
    logic [CNT_W-1:0] split_cnt, luse_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: is slot 2 still owed, and the two event counts
    bit m_pending = 1'b0;
    int m_split   = 0;
    int m_luse    = 0;

    always #5 clk = ~clk;

    dual_issue_ctrl #(
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pair_valid  (pair_valid),
        .s1_dst      (s1_dst),
        .s2_dst      (s2_dst),
        .s1_wr       (s1_wr),
        .s2_wr       (s2_wr),
        .s1_rs       (s1_rs),
        .s1_rt       (s1_rt),
        .s2_rs       (s2_rs),
        .s2_rt       (s2_rt),
        .s1_use_rs   (s1_use_rs),
        .s1_use_rt   (s1_use_rt),
        .s2_use_rs   (s2_use_rs),
        .s2_use_rt   (s2_use_rt),
        .s1_mem      (s1_mem),
        .s2_mem      (s2_mem),
        .s1_ctrl     (s1_ctrl),
        .s2_ctrl     (s2_ctrl),
        .ex_load1    (ex_load1),
        .ex_load2    (ex_load2),
        .ex_dst1     (ex_dst1),
        .ex_dst2     (ex_dst2),
        .redirect_J  (redirect_J),
        .redirect_JR (redirect_JR),
        .redirect_B  (redirect_B),
        .stall_outer (stall_outer),
        .stall_pc    (stall_pc),
        .flush_ifid  (flush_ifid),
        .issue1      (issue1),
        .issue2      (issue2),
        .split_cnt   (split_cnt),
        .luse_cnt    (luse_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Is register r, if read, produced by a load still in EX?
    function automatic bit waits_on_load(input logic [REG_W-1:0] r, input logic used);
        if (!used || r == 0) return 1'b0;
        return (ex_load1 && r == ex_dst1) || (ex_load2 && r == ex_dst2);
    endfunction

    function automatic bit slot1_luse();
        return waits_on_load(s1_rs, s1_use_rs) || waits_on_load(s1_rt, s1_use_rt);
    endfunction

    function automatic bit slot2_luse();
        return waits_on_load(s2_rs, s2_use_rs) || waits_on_load(s2_rt, s2_use_rt);
    endfunction

    // Can the two slots not share a cycle?
    function automatic bit pair_conflict();
        logic [REG_W-1:0] reads[$];
        bit raw = 1'b0;
        if (s2_use_rs) reads.push_back(s2_rs);
        if (s2_use_rt) reads.push_back(s2_rt);
        if (s1_wr && s1_dst != 0) begin
            foreach (reads[i]) if (reads[i] == s1_dst) raw = 1'b1;
        end
        return raw || (s1_wr && s2_wr && s1_dst != 0 && s1_dst == s2_dst) ||
               (s1_mem && s2_mem) || (s1_ctrl && s2_ctrl);
    endfunction

    task automatic clear_inputs();
        pair_valid = 0; s1_dst = 0; s2_dst = 0; s1_wr = 0; s2_wr = 0;
        s1_rs = 0; s1_rt = 0; s2_rs = 0; s2_rt = 0;
        s1_use_rs = 0; s1_use_rt = 0; s2_use_rs = 0; s2_use_rt = 0;
        s1_mem = 0; s2_mem = 0; s1_ctrl = 0; s2_ctrl = 0;
        ex_load1 = 0; ex_load2 = 0; ex_dst1 = 0; ex_dst2 = 0;
        redirect_J = 0; redirect_JR = 0; redirect_B = 0;
    endtask

    task automatic randomize_inputs();
        pair_valid  = ($urandom_range(0, 7) != 0);
        s1_dst      = REG_W'($urandom_range(0, 7));
        s2_dst      = REG_W'($urandom_range(0, 7));
        s1_wr       = 1'($urandom);
        s2_wr       = 1'($urandom);
        s1_rs       = REG_W'($urandom_range(0, 7));
        s1_rt       = REG_W'($urandom_range(0, 7));
        s2_rs       = REG_W'($urandom_range(0, 7));
        s2_rt       = REG_W'($urandom_range(0, 7));
        s1_use_rs   = 1'($urandom);
        s1_use_rt   = 1'($urandom);
        s2_use_rs   = 1'($urandom);
        s2_use_rt   = 1'($urandom);
        s1_mem      = ($urandom_range(0, 2) == 0);
        s2_mem      = ($urandom_range(0, 2) == 0);
        s1_ctrl     = ($urandom_range(0, 3) == 0);
        s2_ctrl     = ($urandom_range(0, 3) == 0);
        ex_load1    = ($urandom_range(0, 3) == 0);
        ex_load2    = ($urandom_range(0, 3) == 0);
        ex_dst1     = REG_W'($urandom_range(0, 7));
        ex_dst2     = REG_W'($urandom_range(0, 7));
        redirect_J  = ($urandom_range(0, 39) == 0);
        redirect_JR = ($urandom_range(0, 39) == 0);
        redirect_B  = ($urandom_range(0, 19) == 0);
    endtask

    // One cycle: called just after a posedge with inputs already applied.
    // Checks outputs mid-cycle, then advances the model at the next posedge.
    task automatic step(input string tag);
        bit e_stall, e_flush, e_i1, e_i2, nxt_pending, inc_split, inc_luse;
        e_stall = 0; e_flush = 0; e_i1 = 0; e_i2 = 0;
        inc_split = 0; inc_luse = 0;
        nxt_pending = m_pending;
        #2;
        if (reset) begin
            m_pending = 0; m_split = 0; m_luse = 0; nxt_pending = 0;
        end else if (redirect_J || redirect_JR || redirect_B) begin
            e_flush = 1; nxt_pending = 0;
        end else if (!m_pending) begin
            if (pair_valid) begin
                if (slot1_luse() || slot2_luse()) begin
                    e_stall = 1; inc_luse = 1;
                end else if (pair_conflict()) begin
                    e_i1 = 1; e_stall = 1; inc_split = 1; nxt_pending = 1;
                end else begin
                    e_i1 = 1; e_i2 = 1;
                end
            end
        end else begin
            if (slot2_luse()) begin
                e_stall = 1; inc_luse = 1;
            end else begin
                e_i2 = 1; nxt_pending = 0;
            end
        end
        check_eq({tag, ".ctl"}, {27'd0, stall_outer, stall_pc, flush_ifid, issue1, issue2},
                 {27'd0, e_stall, e_stall, e_flush, e_i1, e_i2});
        check_eq({tag, ".split_cnt"}, 32'(split_cnt), 32'(m_split));
        check_eq({tag, ".luse_cnt"}, 32'(luse_cnt), 32'(m_luse));
        @(posedge clk);
        if (!reset) begin
            m_pending = nxt_pending;
            if (inc_split && m_split < CNT_MAX) m_split++;
            if (inc_luse && m_luse < CNT_MAX) m_luse++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step("reset");
        // Outputs must stay quiet under reset even with a clean pair presented
        pair_valid = 1; s1_wr = 1; s1_dst = 3;
        step("reset_gate");
        reset = 1'b0;

        // Independent pair dual-issues in the same cycle
        s2_use_rs = 1; s2_rs = 4; s2_use_rt = 1; s2_rt = 5;
        step("indep");

        // RAW through r3 splits; RAW through r0 does not
        s2_rs = 3;
        step("raw_c0");
        step("raw_c1");
        s1_dst = 0; s2_rs = 0;
        step("raw_r0");

        // Load-use on slot 1 for two cycles, then dual issue
        clear_inputs();
        pair_valid = 1; s1_use_rs = 1; s1_rs = 7; ex_load1 = 1; ex_dst1 = 7;
        step("luse0");
        step("luse1");
        ex_load1 = 0;
        step("luse_rel");

        // Redirect while slot 2 is pending drops it
        clear_inputs();
        pair_valid = 1; s1_mem = 1; s2_mem = 1;
        step("mem_split");
        redirect_B = 1;
        step("redir_split");
        redirect_B = 0;

        // Store pair splits again; load-use on slot 2 holds SPLIT one cycle
        step("st_c0");
        s2_use_rs = 1; s2_rs = 9; ex_load2 = 1; ex_dst2 = 9;
        step("st_luse2");
        ex_load2 = 0;
        step("st_issue2");

        // Saturate the split counter, then reset in the middle of a split
        s2_use_rs = 0;
        for (int i = 0; i < 2 * (CNT_MAX + 4); i++) step("sat");
        check_eq("split_sat", 32'(split_cnt), CNT_MAX);
        step("sat_c0");
        reset = 1'b1;
        step("reset_split");
        reset = 1'b0;
        step("post_reset");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 199) == 0);
            step("rand");
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
